block_ram_sp: RTL and testbench
===============================

Name: block_ram_sp

Overview:
- Parametrised single-port synchronous block RAM. Successor to the fixed-geometry 2-bit block RAM primitives.
- Adds configurable width and depth, per-lane write enables, selectable write mode, a programmable reset/init value for the output, and an optional output pipeline register.
- Used as a simulation/behavioural RAM wherever a one-port buffer (line buffer, lookup table, scratch store) is needed.

Parameters:
DATA_WIDTH, 16, data bits per word; must be a multiple of LANE_WIDTH
LANE_WIDTH, 8, bits per write-enable lane
ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH words
WRITE_MODE, 0, 0 = write-first, 1 = read-first, 2 = no-change
SRVAL, 0, DATA_WIDTH-bit value loaded into output registers on reset
INIT_VAL, 0, DATA_WIDTH-bit value every word holds at time zero
(derived) LANES = DATA_WIDTH/LANE_WIDTH

Ports:
CLK  input  1  clock; all activity on rising edge
RST  input  1  synchronous active-high reset of output registers only
EN  input  1  port enable; no read, write or stage-1 reset when low
WE  input  LANES  per-lane write enable, qualified by EN
ADDR  input  ADDR_WIDTH  word address
DI  input  DATA_WIDTH  write data
REGCE  input  1  output-register clock enable; used only with OUTPUT_REG_EN
DO  output  DATA_WIDTH  read data

Behaviour:
- Interface: one clock, CLK; reset is RST, synchronous and active-high. No asynchronous paths.
- Memory contents: every word equals INIT_VAL at time zero. RST never alters memory.
- Write: on a rising edge with EN=1, each lane i with WE[i]=1 stores DI[(i+1)*LANE_WIDTH-1 : i*LANE_WIDTH] at mem[ADDR]. Lanes with WE[i]=0 keep their contents.
- Stage-1 output register (d1) is updated only on an edge with EN=1, with priority:
  - RST=1: d1 <= SRVAL. Any write in the same cycle still occurs.
  - Else, any WE bit set:
    - WRITE_MODE 0: written lanes show DI; unwritten lanes show old mem[ADDR].
    - WRITE_MODE 1: d1 <= old mem[ADDR] (pre-write value) for all lanes.
    - WRITE_MODE 2: d1 holds its previous value.
  - Else (WE all zero): d1 <= mem[ADDR].
- EN=0: d1 holds, memory holds, RST is ignored by stage 1.
- Read latency: 1 cycle (ADDR sampled at edge N, DO valid after edge N). Back-to-back accesses are supported every cycle.
- Same-address read after write: the next-cycle read returns the newly written data in every mode.
- Reset values: DO = SRVAL after any reset edge that takes effect. Before the first reset, DO = SRVAL (time-zero init of all output registers).
- Address range: full 2**ADDR_WIDTH range with no wrap logic. An X or Z bit on ADDR with EN=1 drives d1 to all-X; if WE is also set, a $display warning is issued and no word is written.
- Parameter check at elaboration: DATA_WIDTH % LANE_WIDTH != 0, or WRITE_MODE > 2, produces $display error and $finish.

Optional Feature:
- Macro: BLOCK_RAM_SP_OUTPUT_REG_EN
- Defined: a stage-2 register d2 drives DO, giving read latency 2.
  - d2 <= SRVAL on any edge with RST=1, independent of EN and REGCE.
  - Otherwise d2 <= d1 on edges with REGCE=1, and d2 holds when REGCE=0.
  - Stage-1 RST still requires EN=1.
- Not defined: DO = d1, latency 1, REGCE unused (no lint-sensitive logic on it).

Test Plan:
- Reset and init: INIT_VAL=16'hA5A5, SRVAL=16'h0F0F. Pulse RST with EN=1 -> DO=16'h0F0F. Then read addr 5 -> DO=16'hA5A5 one cycle later; with macro defined, two cycles later.
- Write modes: mem[3]=16'h1111, write DI=16'h2222, WE=2'b11 at addr 3 -> DO=16'h2222 (mode 0), 16'h1111 (mode 1), previous DO unchanged (mode 2). Next-cycle read of addr 3 -> 16'h2222 in all modes.
- Lane enables: mem[7]=16'hAAAA, write DI=16'h5555, WE=2'b01 -> subsequent read of addr 7 = 16'hAA55. In mode 0 the write-cycle DO = 16'hAA55.
- Enable gating: EN=0 with WE=2'b11, DI=16'hFFFF, RST=1 at addr 0 -> mem[0] unchanged and DO unchanged (without macro). Raise EN -> reads return original data.
- Boundaries and throughput: write addr 0 and addr 1023 (ADDR_WIDTH=10) on back-to-back cycles, then read both back-to-back -> correct values on consecutive cycles, no aliasing.
- Pipeline (macro defined): stream reads of addr 0..3 with REGCE=1, then REGCE=0 for 2 cycles -> DO freezes on the last value. Assert RST with EN=0 -> DO=SRVAL next edge.

Source files
------------

// File: rtl/block_ram_sp.sv
// Parametrised single-port synchronous block RAM with per-lane write enables and selectable write mode.
// Define BLOCK_RAM_SP_OUTPUT_REG_EN to add a REGCE-gated output register (read latency 2).
module block_ram_sp #(
   parameter int                        DATA_WIDTH = 16,
   parameter int                        LANE_WIDTH = 8,
   parameter int                        ADDR_WIDTH = 10,
   parameter int                        WRITE_MODE = 0,
   parameter logic [DATA_WIDTH-1:0]     SRVAL      = '0,
   parameter logic [DATA_WIDTH-1:0]     INIT_VAL   = '0,
   localparam int                       LANES      = DATA_WIDTH / LANE_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  EN,
   input  logic [LANES-1:0]      WE,
   input  logic [ADDR_WIDTH-1:0] ADDR,
   input  logic [DATA_WIDTH-1:0] DI,
   input  logic                  REGCE,
   output logic [DATA_WIDTH-1:0] DO
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   if (((DATA_WIDTH % LANE_WIDTH) != 0) || (WRITE_MODE > 2) || (WRITE_MODE < 0)) begin : g_param_err
      $error("block_ram_sp: DATA_WIDTH must be a multiple of LANE_WIDTH and WRITE_MODE must be 0..2");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: INIT_VAL};
   logic [DATA_WIDTH-1:0] d1 = SRVAL;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] wf_word;

   // Write-first view: written lanes take DI, the rest show the stored word.
   always_comb begin
      rd_word = mem[ADDR];
      wf_word = rd_word;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (WE[i]) begin
            wf_word[i*LANE_WIDTH +: LANE_WIDTH] = DI[i*LANE_WIDTH +: LANE_WIDTH];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (EN) begin
         if ($isunknown(ADDR)) begin
            if (RST) begin
               d1 <= SRVAL;
            end else begin
               d1 <= 'x;
            end
            if (|WE) begin
               $warning("block_ram_sp: write with unknown ADDR ignored");
            end
         end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
               if (WE[i]) begin
                  mem[ADDR][i*LANE_WIDTH +: LANE_WIDTH] <= DI[i*LANE_WIDTH +: LANE_WIDTH];
               end
            end
            if (RST) begin
               d1 <= SRVAL;
            end else if (|WE) begin
               if (WRITE_MODE == 0) begin
                  d1 <= wf_word;
               end else if (WRITE_MODE == 1) begin
                  d1 <= rd_word;
               end
            end else begin
               d1 <= rd_word;
            end
         end
      end
   end

`ifdef BLOCK_RAM_SP_OUTPUT_REG_EN
   logic [DATA_WIDTH-1:0] d2 = SRVAL;

   // Stage-2 reset is not qualified by EN or REGCE.
   always_ff @(posedge CLK) begin
      if (RST) begin
         d2 <= SRVAL;
      end else if (REGCE) begin
         d2 <= d1;
      end
   end

   assign DO = d2;
`else
   logic unused_regce;
   assign unused_regce = REGCE;
   assign DO = d1;
`endif

endmodule

// File: tb/tb_block_ram_sp.sv
// Self-checking bench for block_ram_sp: three instances (write-first, read-first, no-change) share stimulus.
// A behavioural model pushes expected DO per cycle into a scoreboard queue; tasks pop and compare after each edge.
module tb_block_ram_sp;

   localparam logic [15:0] SRV  = 16'h0F0F;
   localparam logic [15:0] INIT = 16'hA5A5;

   typedef logic [2:0][15:0] exp_t;

   logic        clk = 1'b0;
   logic        RST = 1'b0;
   logic        EN = 1'b0;
   logic [1:0]  WE = '0;
   logic [9:0]  ADDR = '0;
   logic [15:0] DI = '0;
   logic        REGCE = 1'b1;
   logic [2:0][15:0] dout;

   int n_checks = 0;
   int n_fail = 0;

   exp_t        exp_q[$];
   logic [15:0] m_mem [1024];
   exp_t        m_d1;
   exp_t        m_d2;

   always #5 clk = ~clk;

   block_ram_sp #(.DATA_WIDTH(16), .LANE_WIDTH(8), .ADDR_WIDTH(10), .WRITE_MODE(0),
                  .SRVAL(SRV), .INIT_VAL(INIT))
      u_wf (.CLK(clk), .RST(RST), .EN(EN), .WE(WE), .ADDR(ADDR), .DI(DI), .REGCE(REGCE), .DO(dout[0]));
   block_ram_sp #(.DATA_WIDTH(16), .LANE_WIDTH(8), .ADDR_WIDTH(10), .WRITE_MODE(1),
                  .SRVAL(SRV), .INIT_VAL(INIT))
      u_rf (.CLK(clk), .RST(RST), .EN(EN), .WE(WE), .ADDR(ADDR), .DI(DI), .REGCE(REGCE), .DO(dout[1]));
   block_ram_sp #(.DATA_WIDTH(16), .LANE_WIDTH(8), .ADDR_WIDTH(10), .WRITE_MODE(2),
                  .SRVAL(SRV), .INIT_VAL(INIT))
      u_nc (.CLK(clk), .RST(RST), .EN(EN), .WE(WE), .ADDR(ADDR), .DI(DI), .REGCE(REGCE), .DO(dout[2]));

   // Drives one cycle, advances the model and pushes the expected DO of all three instances.
   task automatic apply(input logic en, input logic [1:0] we, input logic [9:0] addr,
                        input logic [15:0] di, input logic rst, input logic regce);
      logic [15:0] old;
      logic [15:0] merged;
      @(negedge clk);
      EN = en; WE = we; ADDR = addr; DI = di; RST = rst; REGCE = regce;
      old = m_mem[addr];
      merged = old;
      if (we[0]) merged[7:0]  = di[7:0];
      if (we[1]) merged[15:8] = di[15:8];
`ifdef BLOCK_RAM_SP_OUTPUT_REG_EN
      if (rst)        m_d2 = {3{SRV}};
      else if (regce) m_d2 = m_d1;
`endif
      if (en) begin
         if (rst) begin
            m_d1 = {3{SRV}};
         end else if (we != 2'b00) begin
            m_d1[0] = merged;
            m_d1[1] = old;
         end else begin
            m_d1 = {3{old}};
         end
         m_mem[addr] = merged;
      end
`ifdef BLOCK_RAM_SP_OUTPUT_REG_EN
      exp_q.push_back(m_d2);
`else
      exp_q.push_back(m_d1);
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      n_checks++;
      if (dout !== {3{SRV}}) begin
         n_fail++;
         $display("FAIL reset_init: DO=%h required %h", dout, {3{SRV}});
      end
      apply(1'b1, 2'b00, 10'd0, 16'h0000, 1'b1, 1'b1);
      apply(1'b1, 2'b00, 10'd5, 16'h0000, 1'b0, 1'b1);
      apply(1'b0, 2'b00, 10'd5, 16'h0000, 1'b0, 1'b1);
      for (int s = 0; s < 3; s++) begin
         e = exp_q.pop_front();
         if (s == 0) begin
            n_checks++;
            if (e !== {3{SRV}}) begin
               n_fail++;
               $display("FAIL reset_model: model=%h required %h", e, {3{SRV}});
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (dout[k] !== INIT) begin
            n_fail++;
            $display("FAIL reset_read5 inst%0d: DO=%h required %h", k, dout[k], INIT);
         end
      end
   endtask

   task automatic test_write_modes();
      exp_t e;
      logic [1:0]  we_t [4] = '{2'b11, 2'b11, 2'b00, 2'b00};
      logic [15:0] di_t [4] = '{16'h1111, 16'h2222, 16'h0000, 16'h0000};
      logic        en_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      for (int s = 0; s < 4; s++) begin
         apply(en_t[s], we_t[s], 10'd3, di_t[s], 1'b0, 1'b1);
         e = exp_q.pop_front();
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dout[k] !== e[k]) begin
               n_fail++;
               $display("FAIL write_modes step%0d inst%0d: DO=%h required %h", s, k, dout[k], e[k]);
            end
         end
         if (s == 2) begin
            n_checks++;
            if (dout !== {16'hA5A5, 16'h1111, 16'h2222}) begin
               n_fail++;
               $display("FAIL write_modes_plan: DO=%h required %h", dout, {16'hA5A5, 16'h1111, 16'h2222});
            end
         end
      end
      apply(1'b0, 2'b00, 10'd3, 16'h0000, 1'b0, 1'b1);
      void'(exp_q.pop_front());
      n_checks++;
      if (dout !== {3{16'h2222}}) begin
         n_fail++;
         $display("FAIL write_modes_readback: DO=%h required %h", dout, {3{16'h2222}});
      end
   endtask

   task automatic test_lanes();
      exp_t e;
      logic [1:0]  we_t [4] = '{2'b11, 2'b01, 2'b00, 2'b00};
      logic [15:0] di_t [4] = '{16'hAAAA, 16'h5555, 16'h0000, 16'h0000};
      logic        en_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      for (int s = 0; s < 4; s++) begin
         apply(en_t[s], we_t[s], 10'd7, di_t[s], 1'b0, 1'b1);
         e = exp_q.pop_front();
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dout[k] !== e[k]) begin
               n_fail++;
               $display("FAIL lanes step%0d inst%0d: DO=%h required %h", s, k, dout[k], e[k]);
            end
         end
         if (s == 2) begin
            n_checks++;
            if (dout[0] !== 16'hAA55) begin
               n_fail++;
               $display("FAIL lanes_wf_write: DO=%h required %h", dout[0], 16'hAA55);
            end
         end
      end
      apply(1'b0, 2'b00, 10'd7, 16'h0000, 1'b0, 1'b1);
      void'(exp_q.pop_front());
      n_checks++;
      if (dout !== {3{16'hAA55}}) begin
         n_fail++;
         $display("FAIL lanes_readback: DO=%h required %h", dout, {3{16'hAA55}});
      end
   endtask

   task automatic test_enable();
      exp_t e;
      apply(1'b0, 2'b11, 10'd0, 16'hFFFF, 1'b1, 1'b1);
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (dout[k] !== e[k]) begin
            n_fail++;
            $display("FAIL enable_gate inst%0d: DO=%h required %h", k, dout[k], e[k]);
         end
      end
`ifndef BLOCK_RAM_SP_OUTPUT_REG_EN
      n_checks++;
      if (dout !== {3{16'hAA55}}) begin
         n_fail++;
         $display("FAIL enable_hold: DO=%h required %h", dout, {3{16'hAA55}});
      end
`endif
      apply(1'b1, 2'b00, 10'd0, 16'h0000, 1'b0, 1'b1);
      apply(1'b0, 2'b00, 10'd0, 16'h0000, 1'b0, 1'b1);
      exp_q.delete();
      n_checks++;
      if (dout !== {3{INIT}}) begin
         n_fail++;
         $display("FAIL enable_mem_kept: DO=%h required %h", dout, {3{INIT}});
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [1:0]  we_t [6] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
      logic [9:0]  ad_t [6] = '{10'd0, 10'd1023, 10'd0, 10'd1023, 10'd1, 10'd1};
      logic [15:0] di_t [6] = '{16'h1234, 16'hABCD, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      logic        en_t [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [15:0] plan [6] = '{16'h1234, 16'hABCD, 16'h1234, 16'hABCD, INIT, INIT};
      int lat = 1;
`ifdef BLOCK_RAM_SP_OUTPUT_REG_EN
      lat = 2;
`endif
      for (int s = 0; s < 6; s++) begin
         apply(en_t[s], we_t[s], ad_t[s], di_t[s], 1'b0, 1'b1);
         e = exp_q.pop_front();
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dout[k] !== e[k]) begin
               n_fail++;
               $display("FAIL b2b step%0d inst%0d: DO=%h required %h", s, k, dout[k], e[k]);
            end
         end
         if (s >= 1 + lat) begin
            n_checks++;
            if (dout[1] !== plan[s-lat+1]) begin
               n_fail++;
               $display("FAIL b2b_plan step%0d: DO=%h required %h", s, dout[1], plan[s-lat+1]);
            end
         end
      end
   endtask

   task automatic test_random();
      exp_t e;
      logic [9:0] addrs [6] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd512, 10'd1023};
      for (int s = 0; s < 60; s++) begin
         apply(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), addrs[$urandom_range(0, 5)],
               16'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
         e = exp_q.pop_front();
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dout[k] !== e[k]) begin
               n_fail++;
               $display("FAIL random step%0d inst%0d: DO=%h required %h", s, k, dout[k], e[k]);
            end
         end
      end
   endtask

`ifdef BLOCK_RAM_SP_OUTPUT_REG_EN
   task automatic test_pipeline();
      exp_t e;
      logic       rc_t [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic       en_t [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic       rs_t [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [9:0] ad_t [8] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd3, 10'd5, 10'd6, 10'd0};
      for (int s = 0; s < 8; s++) begin
         apply(en_t[s], 2'b00, ad_t[s], 16'h0000, rs_t[s], rc_t[s]);
         e = exp_q.pop_front();
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dout[k] !== e[k]) begin
               n_fail++;
               $display("FAIL pipeline step%0d inst%0d: DO=%h required %h", s, k, dout[k], e[k]);
            end
         end
      end
      n_checks++;
      if (dout !== {3{SRV}}) begin
         n_fail++;
         $display("FAIL pipeline_reset: DO=%h required %h", dout, {3{SRV}});
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 1024; i++) m_mem[i] = INIT;
      m_d1 = {3{SRV}};
      m_d2 = {3{SRV}};
      #1;
      test_reset();
      test_write_modes();
      test_lanes();
      test_enable();
      test_back_to_back();
`ifdef BLOCK_RAM_SP_OUTPUT_REG_EN
      test_pipeline();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
